// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencing controller: state encoding,
// default prescaler settings and counter direction values.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  localparam int DEF_TICK_DIV  = 5000000;
  localparam int DEF_FAST_STEP = 5;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one level button input.
// The rise pulse appears one cycle after the button is first seen high.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev;

  // prev resets high so a button held through reset does not fire on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b1;
      rise <= 1'b0;
    end else begin
      prev <= btn;
      rise <= btn & ~prev;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run state machine, tick prescaler, countdown expiry and lap hold for the
// four-digit stopwatch. All outputs are registered.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int FAST_STEP = DEF_FAST_STEP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  input  logic       dswitch,
  input  logic       time_set,
  input  logic       zero,
  output logic       tick_en,
  output logic       count_up,
  output logic       counter_clr,
  output logic       lap_hold,
  output logic       flash,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV + FAST_STEP);

  state_t        state_q;
  logic          fast;
  logic          armed;
  logic [PW-1:0] presc;
  logic [PW-1:0] step;
  logic [PW-1:0] sum;
  logic          expire;
  logic          clear_e;
  logic          stop_e;
  logic          start_e;
  logic          lap_e;

  btn_edge u_clear (.clk(clk), .reset(reset), .btn(clear), .rise(clear_e));
  btn_edge u_stop  (.clk(clk), .reset(reset), .btn(stop),  .rise(stop_e));
  btn_edge u_start (.clk(clk), .reset(reset), .btn(start), .rise(start_e));
  btn_edge u_lap   (.clk(clk), .reset(reset), .btn(lap),   .rise(lap_e));

  assign step   = fast ? PW'(FAST_STEP) : PW'(1);
  assign sum    = presc + step;
  assign expire = armed & zero & (count_up == DOWN);
  assign state  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_en     <= 1'b0;
      counter_clr <= 1'b0;
      lap_hold    <= 1'b0;
      flash       <= 1'b0;
      count_up    <= UP;
      fast        <= 1'b0;
      armed       <= 1'b0;
      presc       <= '0;
    end else begin
      tick_en     <= 1'b0;
      counter_clr <= 1'b0;
      case (state_q)
        RUN: begin
          // Only edges that act in RUN compete: clear and start are ignored here.
          if (!zero) armed <= 1'b1;
          if (stop_e) begin
            state_q <= PAUSED;
            presc   <= '0;
          end else if (expire) begin
            state_q <= EXPIRED;
            flash   <= 1'b1;
            presc   <= '0;
          end else if (sum >= PW'(TICK_DIV)) begin
            tick_en <= 1'b1;
            presc   <= '0;
          end else begin
            presc <= sum;
          end
          if (!stop_e && lap_e && count_up == UP) lap_hold <= ~lap_hold;
        end
        default: begin
          // Direction and speed track the switches until the next run starts.
          count_up <= dswitch;
          fast     <= time_set;
          presc    <= '0;
          if (clear_e) begin
            state_q     <= IDLE;
            counter_clr <= 1'b1;
            lap_hold    <= 1'b0;
            flash       <= 1'b0;
          end else if (start_e) begin
            state_q  <= RUN;
            lap_hold <= 1'b0;
            flash    <= 1'b0;
            armed    <= 1'b0;
          end else if (lap_e && state_q == PAUSED && count_up == UP) begin
            lap_hold <= ~lap_hold;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=10, FAST_STEP=5,
// using an event-level reference model of the controller.
module tb_stopwatch_ctrl;

  localparam int TD = 10;
  localparam int FS = 5;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_EXPIRED = 2'd3;
  localparam logic [6:0] RESET_VEC = 7'b00_0_1_0_0_0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic dswitch = 1'b1, time_set = 1'b0, zero = 1'b1;
  logic tick_en, count_up, counter_clr, lap_hold, flash;
  logic [1:0] state;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .FAST_STEP(FS)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .lap(lap), .dswitch(dswitch), .time_set(time_set), .zero(zero),
    .tick_en(tick_en), .count_up(count_up), .counter_clr(counter_clr),
    .lap_hold(lap_hold), .flash(flash), .state(state)
  );

  assign obs = {state, tick_en, count_up, counter_clr, lap_hold, flash};

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Buttons: 0 clear, 1 stop, 2 start, 3 lap (priority order).
  logic [1:0] m_state;
  bit m_tick, m_up, m_clr, m_lap, m_flash, m_fast, m_armed;
  int m_run_cnt;
  bit m_prev[4];
  bit m_rise[4];

  function automatic logic [6:0] exp_vec();
    return {m_state, m_tick, m_up, m_clr, m_lap, m_flash};
  endfunction

  function automatic int period(bit f);
    int s;
    s = f ? FS : 1;
    return (TD + s - 1) / s;
  endfunction

  function automatic bit acts(int b, logic [1:0] s, bit up);
    case (b)
      0: return s != S_RUN;
      1: return s == S_RUN;
      2: return s != S_RUN;
      default: return (s == S_RUN || s == S_PAUSED) && up;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_tick = 0; m_up = 1; m_clr = 0; m_lap = 0; m_flash = 0;
    m_fast = 0; m_armed = 0; m_run_cnt = 0;
    for (int b = 0; b < 4; b++) begin m_prev[b] = 1; m_rise[b] = 0; end
  endtask

  task automatic model_edge();
    bit now[4];
    int act;
    logic [1:0] s;
    now[0] = clear; now[1] = stop; now[2] = start; now[3] = lap;
    s = m_state; m_tick = 0; m_clr = 0; act = -1;
    for (int b = 0; b < 4; b++)
      if (act < 0 && m_rise[b] && acts(b, s, m_up)) act = b;
    if (s == S_RUN) begin
      m_run_cnt++;
      if (act == 1) m_state = S_PAUSED;
      else if (m_armed && zero && !m_up) begin m_state = S_EXPIRED; m_flash = 1; end
      else if (m_run_cnt % period(m_fast) == 0) m_tick = 1;
      if (!zero) m_armed = 1;
    end else begin
      if (act == 0) begin m_state = S_IDLE; m_clr = 1; m_lap = 0; m_flash = 0; end
      if (act == 2) begin
        m_state = S_RUN; m_lap = 0; m_flash = 0; m_armed = 0; m_run_cnt = 0;
      end
      m_up = dswitch; m_fast = time_set;
    end
    if (act == 3) m_lap = !m_lap;
    for (int b = 0; b < 4; b++) begin
      m_rise[b] = now[b] && !m_prev[b];
      m_prev[b] = now[b];
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic to_idle();
    start = 0; stop = 0; clear = 0; lap = 0;
    step();
    stop = 1; step(); stop = 0; step();
    clear = 1; step(); clear = 0; step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL reset_values got %b want %b", obs, RESET_VEC);
    end
    reset = 0;
    repeat (3) begin
      step(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset_idle got %b want %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_start_normal();
    int hold;
    dswitch = 1; time_set = 0;
    start = 1; step();
    checks++;
    if (state !== S_IDLE) begin errors++; $display("FAIL start_latency1 got %0d want %0d", state, S_IDLE); end
    step();
    checks++;
    if (state !== S_RUN || count_up !== 1'b1) begin
      errors++; $display("FAIL start_run got state %0d up %b want %0d 1", state, count_up, S_RUN);
    end
    hold = $urandom_range(1, 6);
    for (int i = 1; i <= 30; i++) begin
      if (i == hold) start = 0;
      step(); checks++;
      if (tick_en !== (i % TD == 0) || obs !== exp_vec()) begin
        errors++; $display("FAIL tick_normal i=%0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_fast();
    to_idle();
    dswitch = 1; time_set = 1;
    start = 1; step(); start = 0; step();
    for (int i = 1; i <= 12; i++) begin
      time_set = 1'($urandom_range(0, 1));
      step(); checks++;
      if (tick_en !== (i % 2 == 0) || obs !== exp_vec()) begin
        errors++; $display("FAIL tick_fast i=%0d got %b want %b", i, obs, exp_vec());
      end
    end
    stop = 1; time_set = 0; step(); stop = 0; step();
    checks++;
    if (state !== S_PAUSED) begin errors++; $display("FAIL fast_stop got %0d want %0d", state, S_PAUSED); end
    start = 1; step(); start = 0; step();
    for (int i = 1; i <= 10; i++) begin
      step(); checks++;
      if (tick_en !== (i == 10) || obs !== exp_vec()) begin
        errors++; $display("FAIL tick_slow_again i=%0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_expiry();
    int n;
    bit seen_tick;
    to_idle();
    dswitch = 0; zero = 1;
    start = 1; step(); start = 0; step();
    checks++;
    if (state !== S_RUN || count_up !== 1'b0) begin
      errors++; $display("FAIL down_run got state %0d up %b want %0d 0", state, count_up, S_RUN);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (state !== S_RUN) begin errors++; $display("FAIL unarmed_no_expiry got %0d want %0d", state, S_RUN); end
    zero = 0;
    n = $urandom_range(1, 3);
    repeat (n) step();
    zero = 1; step();
    checks++;
    if (state !== S_EXPIRED || flash !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL expire_entry got %b want %b", obs, exp_vec());
    end
    seen_tick = 0;
    for (int i = 0; i < 25; i++) begin
      zero = 1'($urandom_range(0, 1));
      step();
      if (tick_en) seen_tick = 1;
    end
    checks++;
    if (seen_tick || state !== S_EXPIRED) begin
      errors++; $display("FAIL expired_quiet got tick %b state %0d want 0 %0d", seen_tick, state, S_EXPIRED);
    end
    zero = 1;
    start = 1; step(); start = 0; step();
    checks++;
    if (state !== S_RUN || flash !== 1'b0) begin
      errors++; $display("FAIL expire_restart got state %0d flash %b want %0d 0", state, flash, S_RUN);
    end
    to_idle();
    start = 1; step(); start = 0; step();
    for (int i = 1; i <= 25; i++) begin
      step(); checks++;
      if (state !== S_RUN || tick_en !== (i % TD == 0) || obs !== exp_vec()) begin
        errors++; $display("FAIL down_wrap i=%0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_lap();
    to_idle();
    dswitch = 1; zero = 0;
    start = 1; step(); start = 0; step();
    lap = 1; step(); lap = 0; step();
    checks++;
    if (lap_hold !== 1'b1) begin errors++; $display("FAIL lap_set got %b want 1", lap_hold); end
    repeat ($urandom_range(1, 4)) step();
    lap = 1; step(); lap = 0; step();
    checks++;
    if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_release got %b want 0", lap_hold); end
    lap = 1; step(); lap = 0; step();
    stop = 1; step(); stop = 0; step();
    lap = 1; step(); lap = 0; step();
    checks++;
    if (state !== S_PAUSED || obs !== exp_vec()) begin
      errors++; $display("FAIL lap_paused got %b want %b", obs, exp_vec());
    end
    to_idle();
    dswitch = 0;
    start = 1; step(); start = 0; step();
    lap = 1; step(); lap = 0; step();
    checks++;
    if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_down_ignored got %b want 0", lap_hold); end
  endtask

  task automatic test_clear();
    bit saw_clr;
    to_idle();
    dswitch = 1; zero = 0;
    start = 1; step(); start = 0; step();
    saw_clr = 0;
    clear = 1;
    repeat (5) begin step(); if (counter_clr) saw_clr = 1; end
    clear = 0; step();
    checks++;
    if (saw_clr || state !== S_RUN) begin
      errors++; $display("FAIL clear_in_run got clr %b state %0d want 0 %0d", saw_clr, state, S_RUN);
    end
    stop = 1; clear = 1; step(); stop = 0; clear = 0; step();
    checks++;
    if (state !== S_PAUSED || counter_clr !== 1'b0) begin
      errors++; $display("FAIL stop_clear_same got state %0d clr %b want %0d 0", state, counter_clr, S_PAUSED);
    end
    clear = 1; step(); clear = 0; step();
    checks++;
    if (state !== S_IDLE || counter_clr !== 1'b1) begin
      errors++; $display("FAIL clear_pulse got state %0d clr %b want %0d 1", state, counter_clr, S_IDLE);
    end
    step();
    checks++;
    if (counter_clr !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL clear_one_cycle got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    to_idle();
    dswitch = 1; time_set = 0; zero = 0;
    start = 1; step(); start = 0; step();
    repeat ($urandom_range(3, 7)) step();
    #2 reset = 1;
    start = 1;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL reset_async got %b want %b", obs, RESET_VEC);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    repeat (3) step();
    checks++;
    if (state !== S_IDLE || obs !== exp_vec()) begin
      errors++; $display("FAIL held_through_reset got %b want %b", obs, exp_vec());
    end
    start = 0; step();
    start = 1; step(); start = 0; step();
    checks++;
    if (state !== S_RUN) begin errors++; $display("FAIL restart_run got %0d want %0d", state, S_RUN); end
    for (int i = 1; i <= 10; i++) begin
      step(); checks++;
      if (tick_en !== (i == 10) || obs !== exp_vec()) begin
        errors++; $display("FAIL restart_tick i=%0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) clear = ~clear;
      if ($urandom_range(0, 5) == 0) stop = ~stop;
      if ($urandom_range(0, 4) == 0) start = ~start;
      if ($urandom_range(0, 4) == 0) lap = ~lap;
      if ($urandom_range(0, 9) == 0) dswitch = ~dswitch;
      if ($urandom_range(0, 9) == 0) time_set = ~time_set;
      zero = ($urandom_range(0, 5) == 0);
      step(); checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_normal();
    test_fast();
    test_expiry();
    test_lap();
    test_clear();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the four-digit stopwatch datapath. It turns the raw start/stop/clear/lap buttons and the direction and speed switches into the control signals for the BCD counter and the display latch. It owns the run state machine, the tick prescaler, countdown expiry with flashing, and lap hold. It sits between the board inputs and the counter/display instances in the top level.

## Interface
Parameters:
- TICK_DIV, 5000000: prescaler terminal value; one count tick per TICK_DIV accumulated steps.
- FAST_STEP, 5: prescaler increment per clock in fast mode. Normal mode increments by 1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  start button, level, already synchronous to clk.
- stop  in  1  stop button, level.
- clear  in  1  clear button, level.
- lap  in  1  lap button, level.
- dswitch  in  1  direction switch: 1 = up, 0 = down.
- time_set  in  1  speed switch: 1 = fast (FAST_STEP).
- zero  in  1  from counter: all four digits are 0.
- tick_en  out  1  one-cycle count-enable pulse to the counter.
- count_up  out  1  latched direction to the counter.
- counter_clr  out  1  one-cycle synchronous clear pulse to the counter.
- lap_hold  out  1  1 = display latch frozen; 0 = display latch follows the counter.
- flash  out  1  display blink enable (expiry).
- state  out  2  current state, for debug and LEDs.

## Operation
- Buttons act on rising edges only. There is one edge detector per button; holding a button has no further effect.
- States, as encoded in the package: IDLE=00, RUN=01, PAUSED=10, EXPIRED=11.
- When more than one edge occurs in the same cycle, priority is clear > stop > start > lap. A lower-priority edge in that cycle is dropped.
- clear edge:
  - In IDLE, PAUSED or EXPIRED: pulse counter_clr, go to IDLE, drop lap_hold and flash.
  - In RUN: ignored.
- stop edge:
  - In RUN: go to PAUSED.
  - Otherwise: no effect.
- start edge:
  - In IDLE, PAUSED or EXPIRED: go to RUN, clear lap_hold and flash, clear the armed flag.
  - In RUN: no effect.
- lap edge:
  - Acts only in RUN or PAUSED, and only when count_up=1. It toggles lap_hold.
  - When count_up=0 it is ignored.
- count_up and the fast flag load from dswitch and time_set every cycle while state != RUN. They are frozen while in RUN.
- Prescaler:
  - Width is clog2(TICK_DIV+FAST_STEP).
  - It accumulates only in RUN, adding 1 or FAST_STEP per cycle.
  - When the accumulated value is >= TICK_DIV, tick_en=1 for that cycle and the prescaler loads 0.
  - Outside RUN the prescaler is held at 0, so the first tick after a start arrives exactly TICK_DIV/step cycles later.
- Expiry:
  - In RUN, the armed flag sets when zero=0.
  - When armed=1, zero=1 and count_up=0, the controller goes to EXPIRED and sets flash=1. No tick_en is issued in that cycle or after it.
  - Counting down from 0000 without a nonzero value seen first does not expire; the counter wraps.
- Counting up never expires; the counter wraps 9999 to 0000.

## Timing
- All outputs are registered. On reset: state=IDLE, tick_en=0, counter_clr=0, lap_hold=0, flash=0, count_up=1, prescaler=0, armed=0.
- State change, lap_hold and flash all update on the clock edge after the cycle in which the button is high (edge register plus one cycle).
- counter_clr is high for exactly one cycle, in the same cycle state shows IDLE.
- tick_en is high for exactly one cycle per period. Period is ceil(TICK_DIV/step) cycles.
- EXPIRED is entered one cycle after zero is sampled high with armed=1.
- Reset asserted mid-RUN returns all registers to their reset values immediately (asynchronous). Edges present while reset is active are discarded.

## Structure
- Shared package stopwatch_pkg holds:
  - the state encoding constants;
  - default TICK_DIV and FAST_STEP values;
  - UP/DOWN direction constants.
- One sub-module, btn_edge: a rising-edge detector with one register per input. It is instantiated four times.
- The FSM, prescaler and flags live in stopwatch_ctrl.

## Test plan
All scenarios use TICK_DIV=10.
- Reset, then start edge → state=RUN after 2 cycles; tick_en pulses every 10 cycles; count_up=1.
- time_set=1 in IDLE, then start → tick_en every 2 cycles; toggling time_set during RUN has no effect until stop.
- dswitch=0, start, drive zero 0 then 1 → EXPIRED one cycle later; flash=1; no further tick_en; a start edge clears flash.
- In RUN with count_up=1: lap edge → lap_hold=1; a second lap edge → lap_hold=0. With dswitch=0 loaded, lap is ignored.
- Clear held during RUN → no counter_clr. Stop then clear in the same cycle → PAUSED only. Clear on the next edge → one-cycle counter_clr and IDLE.
- Assert reset mid-RUN, between ticks → outputs at reset values immediately; the first tick after restart arrives a full 10 cycles after RUN.
